// File: rtl/rtc_bus_responder_if.sv
// Strobe group of the multiplexed RTC bus. The 8-bit data lines stay a plain
// inout port on the responder so the tristate resolves on an ordinary wire.
interface rtc_bus_responder_if;
    logic CSI;
    logic ADI;
    logic WRI;
    logic RDI;
    logic bus_oe;

    modport master (output CSI, ADI, WRI, RDI, input bus_oe);
    modport slave  (input CSI, ADI, WRI, RDI, output bus_oe);
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC chip stand-in: BCD register file behind the multiplexed address/data bus,
// with a time-of-day/date counter and a countdown timer advanced once per tick.
module rtc_bus_responder #(
    parameter int unsigned TICK_DIV    = 100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               Reset,
    rtc_bus_responder_if.slave bus,
    inout  wire  [7:0]         Bus_Dato_Dir,
    output logic [7:0]         addr_q,
    output logic               tim_done
);
    localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [SYNC_STAGES-1:0] csi_sync, adi_sync, wri_sync, rdi_sync;
    logic                   csi_s, adi_s, wri_s, rdi_s;
    logic                   wr_active, wr_commit;
    logic [7:0]             cap_q;
    logic                   bus_oe_q;
    logic [DIV_W-1:0]       div_q;
    logic                   tick_raw, tick_pend, tick_go;
    logic [7:0]             sec_q, min_q, hour_q, day_q, mon_q, year_q;
    logic [7:0]             tsec_q, tmin_q, thour_q;
    logic [7:0]             rd_data;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        return (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
    endfunction

    // Strobes idle high, so their synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            csi_sync <= '1;
            wri_sync <= '1;
            rdi_sync <= '1;
            adi_sync <= '0;
        end else begin
            csi_sync <= {csi_sync[SYNC_STAGES-2:0], bus.CSI};
            wri_sync <= {wri_sync[SYNC_STAGES-2:0], bus.WRI};
            rdi_sync <= {rdi_sync[SYNC_STAGES-2:0], bus.RDI};
            adi_sync <= {adi_sync[SYNC_STAGES-2:0], bus.ADI};
        end
    end

    assign csi_s     = csi_sync[SYNC_STAGES-1];
    assign wri_s     = wri_sync[SYNC_STAGES-1];
    assign rdi_s     = rdi_sync[SYNC_STAGES-1];
    assign adi_s     = adi_sync[SYNC_STAGES-1];
    assign wr_commit = wr_active & wri_s;
    assign tick_raw  = (div_q == DIV_LAST);
    assign tick_go   = tick_raw | tick_pend;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_active <= 1'b0;
            cap_q     <= '0;
            bus_oe_q  <= 1'b0;
            addr_q    <= '0;
            div_q     <= '0;
            tick_pend <= 1'b0;
            tim_done  <= 1'b0;
            sec_q     <= '0;
            min_q     <= '0;
            hour_q    <= '0;
            day_q     <= 8'h01;
            mon_q     <= 8'h01;
            year_q    <= '0;
            tsec_q    <= '0;
            tmin_q    <= '0;
            thour_q   <= '0;
        end else begin
            wr_active <= ~csi_s & ~wri_s;
            if (~csi_s & ~wri_s)
                cap_q <= Bus_Dato_Dir;
            bus_oe_q <= ~csi_s & adi_s & ~rdi_s & wri_s;
            div_q    <= tick_raw ? '0 : div_q + 1'b1;
            tim_done <= 1'b0;

            // A commit wins the cycle; a coinciding tick waits one cycle.
            if (wr_commit) begin
                tick_pend <= tick_go;
                if (!adi_s) begin
                    addr_q <= cap_q;
                end else begin
                    case (addr_q)
                        8'h21:   sec_q   <= cap_q;
                        8'h22:   min_q   <= cap_q;
                        8'h23:   hour_q  <= cap_q;
                        8'h24:   day_q   <= cap_q;
                        8'h25:   mon_q   <= cap_q;
                        8'h26:   year_q  <= cap_q;
                        8'h41:   tsec_q  <= cap_q;
                        8'h42:   tmin_q  <= cap_q;
                        8'h43:   thour_q <= cap_q;
                        default: ;
                    endcase
                end
            end else begin
                tick_pend <= tick_raw & tick_pend;
                if (tick_go) begin
                    if (sec_q != 8'h59) sec_q <= bcd_inc(sec_q);
                    else begin
                        sec_q <= '0;
                        if (min_q != 8'h59) min_q <= bcd_inc(min_q);
                        else begin
                            min_q <= '0;
                            if (hour_q != 8'h23) hour_q <= bcd_inc(hour_q);
                            else begin
                                hour_q <= '0;
                                if (day_q != 8'h31) day_q <= bcd_inc(day_q);
                                else begin
                                    day_q <= 8'h01;
                                    if (mon_q != 8'h12) mon_q <= bcd_inc(mon_q);
                                    else begin
                                        mon_q  <= 8'h01;
                                        year_q <= (year_q == 8'h99) ? '0 : bcd_inc(year_q);
                                    end
                                end
                            end
                        end
                    end

                    if ({thour_q, tmin_q, tsec_q} != '0) begin
                        tim_done <= ({thour_q, tmin_q, tsec_q} == 24'h00_00_01);
                        if (tsec_q != '0) tsec_q <= bcd_dec(tsec_q);
                        else begin
                            tsec_q <= 8'h59;
                            if (tmin_q != '0) tmin_q <= bcd_dec(tmin_q);
                            else begin
                                tmin_q  <= 8'h59;
                                thour_q <= bcd_dec(thour_q);
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr_q)
            8'h21:   rd_data = sec_q;
            8'h22:   rd_data = min_q;
            8'h23:   rd_data = hour_q;
            8'h24:   rd_data = day_q;
            8'h25:   rd_data = mon_q;
            8'h26:   rd_data = year_q;
            8'h41:   rd_data = tsec_q;
            8'h42:   rd_data = tmin_q;
            8'h43:   rd_data = thour_q;
            default: rd_data = '0;
        endcase
    end

    assign Bus_Dato_Dir = bus_oe_q ? rd_data : 8'hzz;
    assign bus.bus_oe   = bus_oe_q;
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed/random bus transactions against an integer-valued calendar and
// timer model; every clock edge also checks tim_done against the model.
module tb_rtc_bus_responder;
    localparam int T  = 4;
    localparam int SS = 2;

    logic       CLK      = 1'b0;
    logic       Reset    = 1'b0;
    wire  [7:0] Bus_Dato_Dir;
    logic [7:0] drv_data = '0;
    logic       drv_en   = 1'b0;
    logic [7:0] addr_q;
    logic       tim_done;

    rtc_bus_responder_if bus ();
    assign Bus_Dato_Dir = drv_en ? drv_data : 8'hzz;

    rtc_bus_responder #(.TICK_DIV(T), .SYNC_STAGES(SS)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .bus          (bus),
        .Bus_Dato_Dir (Bus_Dato_Dir),
        .addr_q       (addr_q),
        .tim_done     (tim_done)
    );

    always #5 CLK = ~CLK;

    int         errors = 0;
    int         checks = 0;
    int         m_sec, m_min, m_hour, m_day, m_mon, m_year, m_tt;
    logic [7:0] m_addr, commit_val;
    int         edge_n, commit_at, done_seen;
    bit         commit_adi, pend, exp_done;

    function automatic logic [7:0] to_bcd(int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic int from_bcd(logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] model_reg(logic [7:0] a);
        case (a)
            8'h21:   return to_bcd(m_sec);
            8'h22:   return to_bcd(m_min);
            8'h23:   return to_bcd(m_hour);
            8'h24:   return to_bcd(m_day);
            8'h25:   return to_bcd(m_mon);
            8'h26:   return to_bcd(m_year);
            8'h41:   return to_bcd(m_tt % 60);
            8'h42:   return to_bcd((m_tt / 60) % 60);
            8'h43:   return to_bcd(m_tt / 3600);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_write(logic [7:0] a, logic [7:0] v);
        int th = m_tt / 3600;
        int tm = (m_tt / 60) % 60;
        int ts = m_tt % 60;
        case (a)
            8'h21:   m_sec  = from_bcd(v);
            8'h22:   m_min  = from_bcd(v);
            8'h23:   m_hour = from_bcd(v);
            8'h24:   m_day  = from_bcd(v);
            8'h25:   m_mon  = from_bcd(v);
            8'h26:   m_year = from_bcd(v);
            8'h41:   ts     = from_bcd(v);
            8'h42:   tm     = from_bcd(v);
            8'h43:   th     = from_bcd(v);
            default: ;
        endcase
        m_tt = th * 3600 + tm * 60 + ts;
    endtask

    task automatic model_tick();
        m_sec++;
        if (m_sec == 60)   begin m_sec = 0;  m_min++;  end
        if (m_min == 60)   begin m_min = 0;  m_hour++; end
        if (m_hour == 24)  begin m_hour = 0; m_day++;  end
        if (m_day == 32)   begin m_day = 1;  m_mon++;  end
        if (m_mon == 13)   begin m_mon = 1;  m_year++; end
        if (m_year == 100) m_year = 0;
        if (m_tt != 0) begin
            m_tt--;
            exp_done = (m_tt == 0);
        end
    endtask

    task automatic model_edge();
        bit tick;
        edge_n++;
        tick     = (edge_n % T == 0);
        exp_done = 1'b0;
        if (edge_n == commit_at) begin
            if (commit_adi) model_write(m_addr, commit_val);
            else            m_addr = commit_val;
            pend      = pend | tick;
            commit_at = -1;
        end else if (tick || pend) begin
            pend = tick && pend;
            model_tick();
        end
    endtask

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("tim_done", {7'd0, tim_done}, {7'd0, exp_done});
        if (exp_done) done_seen++;
    endtask

    task automatic wr_byte(bit adi, logic [7:0] v);
        bus.CSI  = 1'b0;
        bus.ADI  = adi;
        drv_data = v;
        drv_en   = 1'b1;
        bus.WRI  = 1'b0;
        repeat (SS + 2) step();
        bus.WRI    = 1'b1;
        bus.CSI    = 1'b1;
        commit_at  = edge_n + SS + 1;
        commit_adi = adi;
        commit_val = v;
        repeat (SS + 2 + int'($urandom_range(0, 2))) step();
        drv_en = 1'b0;
    endtask

    task automatic wr_reg(logic [7:0] a, logic [7:0] v);
        wr_byte(1'b0, a);
        chk("addr_q", addr_q, a);
        wr_byte(1'b1, v);
    endtask

    task automatic rd_reg(logic [7:0] a);
        wr_byte(1'b0, a);
        bus.CSI = 1'b0;
        bus.ADI = 1'b1;
        bus.RDI = 1'b0;
        repeat (SS) step();
        chk("oe_early", {7'd0, bus.bus_oe}, 8'd0);
        step();
        chk("oe_rise", {7'd0, bus.bus_oe}, 8'd1);
        chk($sformatf("rd_%02h", a), Bus_Dato_Dir, model_reg(a));
        step();
        bus.RDI = 1'b1;
        bus.CSI = 1'b1;
        repeat (SS) step();
        chk("oe_hold", {7'd0, bus.bus_oe}, 8'd1);
        step();
        chk("oe_fall", {7'd0, bus.bus_oe}, 8'd0);
        repeat (int'($urandom_range(1, 3))) step();
    endtask

    task automatic rd_all();
        for (int i = 0; i < 6; i++) rd_reg(8'(8'h21 + i));
        for (int i = 0; i < 3; i++) rd_reg(8'(8'h41 + i));
    endtask

    task automatic do_reset();
        Reset   = 1'b0;
        bus.CSI = 1'b1;
        bus.WRI = 1'b1;
        bus.RDI = 1'b1;
        bus.ADI = 1'b0;
        drv_en  = 1'b0;
        m_sec = 0; m_min = 0; m_hour = 0; m_day = 1; m_mon = 1; m_year = 0;
        m_tt = 0; m_addr = '0; edge_n = 0; pend = 1'b0; commit_at = -1; exp_done = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_oe", {7'd0, bus.bus_oe}, 8'd0);
        chk("rst_addr", addr_q, 8'h00);
        chk("rst_done", {7'd0, tim_done}, 8'd0);
        Reset = 1'b1;
    endtask

    logic [7:0] clk_addr [6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    int         lo_v     [6] = '{0, 0, 0, 1, 1, 0};
    int         hi_v     [6] = '{59, 59, 23, 31, 12, 99};

    initial begin
        done_seen = 0;

        // reset values
        do_reset();
        for (int i = 0; i < 6; i++) rd_reg(clk_addr[i]);

        // directed and random register writes with read-back
        wr_reg(8'h22, 8'h10);
        wr_reg(8'h23, 8'h08);
        wr_reg(8'h24, 8'h15);
        wr_reg(8'h25, 8'h03);
        wr_reg(8'h26, 8'h16);
        for (int i = 0; i < 6; i++) rd_reg(clk_addr[i]);
        for (int n = 0; n < 6; n++) begin
            int k = int'($urandom_range(0, 5));
            int v = int'($urandom_range(hi_v[k], lo_v[k]));
            wr_reg(clk_addr[k], to_bcd(v));
            rd_reg(clk_addr[k]);
        end

        // full calendar rollover
        wr_reg(8'h26, 8'h99);
        wr_reg(8'h25, 8'h12);
        wr_reg(8'h24, 8'h31);
        wr_reg(8'h23, 8'h23);
        wr_reg(8'h22, 8'h59);
        wr_reg(8'h21, 8'h59);
        repeat (T) step();
        for (int i = 0; i < 6; i++) rd_reg(clk_addr[i]);

        // timer countdown, expiry pulse, hold at zero
        wr_reg(8'h43, 8'h04);
        wr_reg(8'h42, 8'h03);
        wr_reg(8'h41, 8'h02);
        rd_reg(8'h41);
        rd_reg(8'h42);
        rd_reg(8'h43);
        wr_reg(8'h43, 8'h00);
        wr_reg(8'h42, 8'h00);
        wr_reg(8'h41, 8'h01);
        repeat (6 * T) step();
        chk("done_pulses", 8'(done_seen), 8'd1);
        rd_all();
        wr_reg(8'h42, to_bcd(int'($urandom_range(1, 59))));
        wr_reg(8'h41, 8'h00);
        repeat (4 * T) step();
        rd_all();

        // data commit coinciding with a tick edge, then unmapped/transfer writes
        wr_byte(1'b0, 8'h21);
        while ((edge_n + 2 * SS + 3) % T != 0) step();
        wr_byte(1'b1, 8'h30);
        rd_reg(8'h21);
        wr_reg(8'h30, 8'h55);
        rd_reg(8'h30);
        wr_reg(8'hF0, 8'h77);
        rd_reg(8'hF0);
        rd_all();

        // reset asserted during a read
        wr_byte(1'b0, 8'h24);
        bus.CSI = 1'b0;
        bus.ADI = 1'b1;
        bus.RDI = 1'b0;
        repeat (SS + 1) step();
        chk("pre_rst_oe", {7'd0, bus.bus_oe}, 8'd1);
        #2 Reset = 1'b0;
        #1;
        chk("async_oe", {7'd0, bus.bus_oe}, 8'd0);
        chk("async_addr", addr_q, 8'h00);
        do_reset();
        rd_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
